mem_arbiter: RTL and testbench

//  Shares the single-ported main memory between the I-cache and D-cache miss

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache miss accesses onto a single-ported,
// fixed-latency main memory and returns read data plus a one-cycle done pulse.
// Optional feature: define ARB_RR_EN for a round-robin tie-break (default is
// fixed D-over-I priority).
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 4,
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ic_req,
   input  logic [AW-1:0] ic_addr,
   output logic [DW-1:0] ic_rdata,
   output logic          ic_done,
   input  logic          dc_req,
   input  logic          dc_wr,
   input  logic [AW-1:0] dc_addr,
   input  logic [DW-1:0] dc_wdata,
   output logic [DW-1:0] dc_rdata,
   output logic          dc_done,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int unsigned CW = $clog2(MEM_LAT + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          gnt_dc_q, gnt_dc_d;     // 1 = current access belongs to D-cache
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_wr_q, mem_wr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] ic_rdata_q, ic_rdata_d;
   logic [DW-1:0] dc_rdata_q, dc_rdata_d;
   logic          pick_dc;

`ifdef ARB_RR_EN
   logic          last_dc_q, last_dc_d;   // last_grant: 0 = I, 1 = D

   // Round-robin tie-break: on a tie, grant whoever did not win last time.
   always_comb begin
      pick_dc = dc_req & (~ic_req | ~last_dc_q);
   end
`else
   // Fixed priority: D-cache misses stall MEM, so D always wins a tie.
   always_comb begin
      pick_dc = dc_req;
   end
`endif

   // Next-state logic: arbitration, capture, latency countdown and read-data return.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_dc_d    = gnt_dc_q;
      mem_addr_d  = mem_addr_q;
      mem_wr_d    = mem_wr_q;
      mem_wdata_d = mem_wdata_q;
      ic_rdata_d  = ic_rdata_q;
      dc_rdata_d  = dc_rdata_q;
`ifdef ARB_RR_EN
      last_dc_d   = last_dc_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (dc_req | ic_req) begin
               gnt_dc_d   = pick_dc;
               mem_addr_d = pick_dc ? dc_addr : ic_addr;
               // I-cache is read-only; its write data keeps the previous value.
               mem_wr_d   = pick_dc & dc_wr;
               if (pick_dc) begin
                  mem_wdata_d = dc_wdata;
               end
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = CW'(MEM_LAT);
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q - CW'(1);
            // cnt_q == 1 is the cycle MEM_LAT after mem_en, when mem_rdata is valid.
            if (cnt_q == CW'(1)) begin
               if (!mem_wr_q) begin
                  if (gnt_dc_q) begin
                     dc_rdata_d = mem_rdata;
                  end else begin
                     ic_rdata_d = mem_rdata;
                  end
               end
               state_d = StDone;
            end
         end
         StDone: begin
`ifdef ARB_RR_EN
            last_dc_d = gnt_dc_q;
`endif
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         gnt_dc_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
`ifdef ARB_RR_EN
         last_dc_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_dc_q    <= gnt_dc_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
         ic_rdata_q  <= ic_rdata_d;
         dc_rdata_q  <= dc_rdata_d;
`ifdef ARB_RR_EN
         last_dc_q   <= last_dc_d;
`endif
      end
   end

   // Outputs decoded from state; data outputs come straight from registers.
   always_comb begin
      mem_en    = (state_q == StIssue);
      busy      = (state_q != StIdle);
      ic_done   = (state_q == StDone) & ~gnt_dc_q;
      dc_done   = (state_q == StDone) & gnt_dc_q;
      mem_wr    = mem_wr_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      ic_rdata  = ic_rdata_q;
      dc_rdata  = dc_rdata_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters and a behavioural memory drive mem_arbiter;
// a transaction-level model predicts grant order, cycle timing and data.
module tb_mem_arbiter;

   localparam int unsigned MEM_LAT = 4;
   localparam int unsigned AW      = 16;
   localparam int unsigned DW      = 16;

   logic          clk;
   logic          rst_n;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic [DW-1:0] ic_rdata;
   logic          ic_done;
   logic          dc_req;
   logic          dc_wr;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_wdata;
   logic [DW-1:0] dc_rdata;
   logic          dc_done;
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   mem_arbiter #(
      .MEM_LAT(MEM_LAT),
      .AW     (AW),
      .DW     (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ic_req   (ic_req),
      .ic_addr  (ic_addr),
      .ic_rdata (ic_rdata),
      .ic_done  (ic_done),
      .dc_req   (dc_req),
      .dc_wr    (dc_wr),
      .dc_addr  (dc_addr),
      .dc_wdata (dc_wdata),
      .dc_rdata (dc_rdata),
      .dc_done  (dc_done),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   // Clock starts high so the first negedge precedes the first posedge.
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rst_cnt;

   // Memory device (answers the DUT) and reference image (answers the model).
   logic [DW-1:0] dev_mem [16];
   logic [DW-1:0] ref_mem [16];
   int            pend_cyc = -1;
   logic [DW-1:0] pend_data;

   // Transaction model: one access in flight, timed from its grant cycle.
   bit            m_busy;
   bit            m_dc;
   bit            last_dc;
   int            m_issue;
   int            m_done;
   bit            m_wr;
   logic [DW-1:0] m_rdval;
   logic [AW-1:0] e_addr;
   logic          e_wr;
   logic [DW-1:0] e_wdata;
   logic [DW-1:0] e_ic_rdata;
   logic [DW-1:0] e_dc_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 1'b0;
      last_dc    = 1'b0;
      e_addr     = '0;
      e_wr       = 1'b0;
      e_wdata    = '0;
      e_ic_rdata = '0;
      e_dc_rdata = '0;
   endtask

   // One clock cycle: check outputs, serve memory, drive requesters, advance model.
   task automatic tick(input int p_ic, input int p_dc, input int p_rst);
      bit ic_fin;
      bit dc_fin;
      bit pick;
      @(negedge clk);
      if (m_busy && cyc == m_done && !m_wr) begin
         if (m_dc) e_dc_rdata = m_rdval;
         else      e_ic_rdata = m_rdval;
      end
      if (cyc > 0) begin
         check("busy",      32'(busy),      32'(m_busy));
         check("mem_en",    32'(mem_en),    32'(m_busy && cyc == m_issue));
         check("ic_done",   32'(ic_done),   32'(m_busy && cyc == m_done && !m_dc));
         check("dc_done",   32'(dc_done),   32'(m_busy && cyc == m_done && m_dc));
         check("mem_addr",  32'(mem_addr),  32'(e_addr));
         check("mem_wr",    32'(mem_wr),    32'(e_wr));
         check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         check("ic_rdata",  32'(ic_rdata),  32'(e_ic_rdata));
         check("dc_rdata",  32'(dc_rdata),  32'(e_dc_rdata));
      end

      // Memory device: writes land at mem_en, reads return MEM_LAT cycles later.
      if (mem_en === 1'b1) begin
         if (mem_wr === 1'b1) begin
            dev_mem[mem_addr[3:0]] = mem_wdata;
         end else begin
            pend_cyc  = cyc + MEM_LAT;
            pend_data = dev_mem[mem_addr[3:0]];
         end
      end
      mem_rdata = (cyc == pend_cyc) ? pend_data : DW'($urandom);

      // Requesters: drop on done, scramble inputs while being served, else maybe raise.
      ic_fin = m_busy && cyc == m_done && !m_dc;
      dc_fin = m_busy && cyc == m_done && m_dc;
      if (ic_fin) begin
         ic_req = 1'b0;
      end else if (ic_req && m_busy && !m_dc) begin
         ic_addr = AW'($urandom);
      end else if (!ic_req && int'($urandom_range(0, 99)) < p_ic) begin
         ic_req  = 1'b1;
         ic_addr = AW'($urandom);
      end
      if (dc_fin) begin
         dc_req = 1'b0;
      end else if (dc_req && m_busy && m_dc) begin
         dc_addr  = AW'($urandom);
         dc_wdata = DW'($urandom);
         dc_wr    = 1'($urandom);
      end else if (!dc_req && int'($urandom_range(0, 99)) < p_dc) begin
         dc_req   = 1'b1;
         dc_addr  = AW'($urandom);
         dc_wdata = DW'($urandom);
         dc_wr    = 1'($urandom);
      end

      if (rst_cnt > 0) rst_cnt--;
      else if (int'($urandom_range(0, 999)) < p_rst) rst_cnt = 2;
      rst_n = (rst_cnt == 0);

      // Model update for the coming edge.
      if (!rst_n) begin
         model_reset();
      end else if (m_busy) begin
         if (cyc == m_done) m_busy = 1'b0;
      end else if (ic_req || dc_req) begin
`ifdef ARB_RR_EN
         pick = dc_req && (!ic_req || !last_dc);
`else
         pick = dc_req;
`endif
         m_dc    = pick;
         last_dc = pick;
         m_busy  = 1'b1;
         m_issue = cyc + 1;
         m_done  = cyc + MEM_LAT + 2;
         e_addr  = pick ? dc_addr : ic_addr;
         m_wr    = pick && dc_wr;
         e_wr    = m_wr;
         if (pick) e_wdata = dc_wdata;
         m_rdval = ref_mem[e_addr[3:0]];
         if (m_wr) ref_mem[e_addr[3:0]] = dc_wdata;
      end
      cyc++;
   endtask

   initial begin
      rst_n     = 1'b0;
      rst_cnt   = 3;
      ic_req    = 1'b0;
      ic_addr   = '0;
      dc_req    = 1'b0;
      dc_wr     = 1'b0;
      dc_addr   = '0;
      dc_wdata  = '0;
      mem_rdata = '0;
      pend_data = '0;
      m_dc      = 1'b0;
      m_wr      = 1'b0;
      m_issue   = 0;
      m_done    = 0;
      m_rdval   = '0;
      for (int i = 0; i < 16; i++) begin
         dev_mem[i] = DW'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      model_reset();

      // Reset, then quiet cycles: every output must read zero.
      repeat (4) tick(0, 0, 0);
      // I-cache reads alone.
      repeat (30) tick(100, 0, 0);
      repeat (10) tick(0, 0, 0);
      // D-cache reads and writes alone.
      repeat (40) tick(0, 100, 0);
      repeat (10) tick(0, 0, 0);
      // Both held continuously: exercises the tie-break order.
      repeat (60) tick(100, 100, 0);
      repeat (10) tick(0, 0, 0);
      // Mixed random traffic with occasional resets in any state.
      repeat (3000) tick(35, 35, 8);
      // Drain.
      repeat (20) tick(0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
